imm_ext_unit: RTL and testbench

Parametrised, registered immediate-extension stage for the RISC datapath; successor to the combinational 6→16 sign extender. Converts an IN_W-bit instruction constant into an OUT_W-bit operand using one of four extension/shift modes, and supports a prefix instruction that supplies the upper OUT_W−IN_W bits for the next immediate. Sits between decode and the operand mux, with one pipeline register, stall and flush.

---
 rtl/proc_pkg.sv | 19 +
 rtl/imm_ext_comb.sv | 31 +++
 rtl/imm_ext_unit.sv | 86 ++++++++
 tb/tb_imm_ext_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared datapath definitions: immediate extension modes, prefix FSM states, default widths.
package proc_pkg;

  localparam int IN_W_DEF  = 6;
  localparam int OUT_W_DEF = 16;

  typedef enum logic [1:0] {
    IMM_SEXT = 2'b00,
    IMM_ZEXT = 2'b01,
    IMM_ZSHR = 2'b10,
    IMM_SSHR = 2'b11
  } imm_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } pfx_state_e;

endpackage

// File: rtl/imm_ext_comb.sv
// Pure combinational extend/shift of a SRC_W-bit value to OUT_W bits.
// With SRC_W == OUT_W the extension is a pass-through and only the shift modes act.
module imm_ext_comb
  import proc_pkg::*;
#(
  parameter int SRC_W = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [SRC_W-1:0] src_i,
  input  imm_mode_e        mode_i,
  output logic [OUT_W-1:0] res_o
);

  logic [OUT_W-1:0] zx;
  logic [OUT_W-1:0] sx;

  assign zx = OUT_W'(src_i);
  assign sx = OUT_W'($signed(src_i));

  always_comb begin
    res_o = zx;
    unique case (mode_i)
      IMM_SEXT: res_o = sx;
      IMM_ZEXT: res_o = zx;
      IMM_ZSHR: res_o = {1'b0, zx[OUT_W-1:1]};
      IMM_SSHR: res_o = {sx[OUT_W-1], sx[OUT_W-1:1]};
      default:  res_o = zx;
    endcase
  end

endmodule

// File: rtl/imm_ext_unit.sv
// Registered immediate-extension stage with a prefix FSM that supplies upper operand bits.
// State table: IDLE | no prefix pending ; ARMED | pfx_q holds upper bits for next immediate
module imm_ext_unit
  import proc_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [IN_W-1:0]       in_imm,
  input  logic [1:0]            mode,
  input  logic                  pfx_load,
  input  logic [OUT_W-IN_W-1:0] pfx_data,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [OUT_W-1:0]      out_imm,
  output logic                  pfx_pending
);

  localparam int PFX_W = OUT_W - IN_W;

  pfx_state_e       state_q;
  logic [PFX_W-1:0] pfx_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_imm_q;

  imm_mode_e        mode_e;
  logic [OUT_W-1:0] ext_idle;
  logic [OUT_W-1:0] ext_armed;
  logic [OUT_W-1:0] ext_d;
  logic             accept_imm;
  logic             accept_pfx;

  assign mode_e = imm_mode_e'(mode);

  imm_ext_comb #(.SRC_W(IN_W), .OUT_W(OUT_W)) u_ext_idle (
    .src_i  (in_imm),
    .mode_i (mode_e),
    .res_o  (ext_idle)
  );

  // Armed base is already full width, so only the shift modes change it.
  imm_ext_comb #(.SRC_W(OUT_W), .OUT_W(OUT_W)) u_ext_armed (
    .src_i  ({pfx_q, in_imm}),
    .mode_i (mode_e),
    .res_o  (ext_armed)
  );

  assign ext_d      = (state_q == ST_ARMED) ? ext_armed : ext_idle;
  assign accept_imm = in_valid & ~stall & ~flush;
  assign accept_pfx = pfx_load & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pfx_q       <= '0;
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= accept_imm;
      if (accept_imm) begin
        out_imm_q <= ext_d;
      end
      // A same-cycle prefix arms after the immediate has used the old prefix.
      if (accept_pfx) begin
        pfx_q   <= pfx_data;
        state_q <= ST_ARMED;
      end else if (accept_imm) begin
        state_q <= ST_IDLE;
      end
    end
  end

  assign in_ready    = ~stall;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign pfx_pending = (state_q == ST_ARMED);

endmodule

// File: tb/tb_imm_ext_unit.sv
// Randomized + directed bench for imm_ext_unit with a queue-based scoreboard and arithmetic reference model.
module tb_imm_ext_unit;

  localparam int IN_W  = 6;
  localparam int OUT_W = 16;
  localparam int PFX_W = OUT_W - IN_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       mode;
  logic             pfx_load;
  logic [PFX_W-1:0] pfx_data;
  logic             stall;
  logic             flush;
  logic             in_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_imm;
  logic             pfx_pending;

  always #5 clk = ~clk;

  imm_ext_unit #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_imm      (in_imm),
    .mode        (mode),
    .pfx_load    (pfx_load),
    .pfx_data    (pfx_data),
    .stall       (stall),
    .flush       (flush),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_imm     (out_imm),
    .pfx_pending (pfx_pending)
  );

  int checks = 0;
  int errors = 0;

  logic [OUT_W-1:0] sb_q[$];
  bit               m_armed = 0;
  int               m_pfx   = 0;
  bit               m_valid = 0;
  logic [OUT_W-1:0] m_imm   = '0;
  bit               hold_s  = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: build the integer value, interpret it signed when the mode says so, halve for shift modes.
  function automatic logic [OUT_W-1:0] ref_ext(bit armed, int pfx, int imm, int md);
    int v;
    int w;
    w = armed ? OUT_W : IN_W;
    v = armed ? (pfx * (1 << IN_W) + imm) : imm;
    if ((md == 0 || md == 3) && v >= (1 << (w - 1))) v = v - (1 << w);
    if (md >= 2) v = v >>> 1;
    return OUT_W'(v);
  endfunction

  task automatic step(bit v, int md, int imm, bit pl = 0, int pd = 0,
                      bit st = 0, bit fl = 0, bit r = 0);
    logic [OUT_W-1:0] e;
    in_valid = v;
    mode     = 2'(md);
    in_imm   = IN_W'(imm);
    pfx_load = pl;
    pfx_data = PFX_W'(pd);
    stall    = st;
    flush    = fl;
    rst      = r;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!st));
    if (r) begin
      m_armed = 0; m_pfx = 0; m_valid = 0; m_imm = '0;
    end else if (fl) begin
      m_valid = 0; m_armed = 0;
    end else if (!st) begin
      m_valid = v;
      if (v) begin
        e = ref_ext(m_armed, m_pfx, imm % (1 << IN_W), md % 4);
        sb_q.push_back(e);
        m_imm = e;
      end
      if (pl) begin
        m_pfx = pd % (1 << PFX_W);
        m_armed = 1;
      end else if (v) begin
        m_armed = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_imm", 32'(out_imm), 32'(m_imm));
    chk("pfx_pending", 32'(pfx_pending), 32'(m_armed));
  endtask

  always @(posedge clk) hold_s <= stall && !flush && !rst;

  always @(negedge clk) begin
    if (out_valid === 1'b1 && !hold_s) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got out_imm %0h expected no output", out_imm);
      end else begin
        logic [OUT_W-1:0] e;
        e = sb_q.pop_front();
        if (out_imm !== e) begin
          errors++;
          $display("FAIL sb_data: got %0h expected %0h", out_imm, e);
        end
      end
    end
  end

  initial begin
    in_valid = 0; in_imm = '0; mode = '0; pfx_load = 0; pfx_data = '0;
    stall = 0; flush = 0; rst = 1;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);

    step(1, 0, 'h26);          chk("plan_sext_neg", 32'(out_imm), 32'h0000FFE6);
    step(1, 0, 'h15);          chk("plan_sext_pos", 32'(out_imm), 32'h00000015);
    step(1, 1, 'h26);          chk("plan_zext", 32'(out_imm), 32'h00000026);
    step(1, 2, 'h26);          chk("plan_zshr", 32'(out_imm), 32'h00000013);
    step(1, 3, 'h26);          chk("plan_sshr", 32'(out_imm), 32'h0000FFF3);
    step(0, 0, 0, 1, 'h2AB);   chk("plan_armed", 32'(pfx_pending), 32'h1);
    step(1, 0, 'h15);          chk("plan_pfx_sext", 32'(out_imm), 32'h0000AAD5);
    chk("plan_disarm", 32'(pfx_pending), 32'h0);
    step(0, 0, 0, 1, 'h2AB);
    step(1, 3, 'h15);          chk("plan_pfx_sshr", 32'(out_imm), 32'h0000D56A);
    step(1, 0, 'h3F, 1, 'h001); chk("plan_same_cyc", 32'(out_imm), 32'h0000FFFF);
    chk("plan_same_arm", 32'(pfx_pending), 32'h1);
    step(1, 1, 'h00);          chk("plan_after_same", 32'(out_imm), 32'h00000040);
    step(0, 0, 0);
    repeat (3) step(1, 0, 'h01, 0, 0, 1);
    step(1, 0, 'h01);          chk("plan_stall_rel", 32'(out_imm), 32'h00000001);
    step(1, 1, 'h2A);
    repeat (2) step(1, 0, 'h05, 1, 'h3FF, 1);
    step(0, 0, 0);
    step(0, 0, 0, 1, 'h2AB);
    step(1, 0, 'h15, 0, 0, 0, 1);
    chk("plan_flush_arm", 32'(pfx_pending), 32'h0);
    step(1, 0, 'h3F);          chk("plan_post_flush", 32'(out_imm), 32'h0000FFFF);
    step(0, 0, 0, 1, 'h2AB);
    step(1, 0, 'h15, 0, 0, 0, 0, 1);
    chk("plan_rst_zero", 32'(out_imm), 32'h0);
    step(1, 0, 'h3F);          chk("plan_post_rst", 32'(out_imm), 32'h0000FFFF);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 63),
           $urandom_range(0, 3) == 0, $urandom_range(0, 1023),
           $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 63) == 0);
    end

    step(0, 0, 0);
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) step(0, 0, 0);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
